// File: rtl/ras.sv
// ras -- return address stack for the fetch predictors.
//
// A RAS_ENTRIES-deep circular stack of 38-bit return targets. The prediction
// stage pushes on link-type jumps, pops on returns, and replaces the top on a
// return-and-link. The top entry is presented combinationally as the predicted
// return target. The pointer and count are exported so the ROB side can
// checkpoint them and restore them on a mispredict.
//
// Configuration macro: LOROF_RAS_UNDERFLOW_PROTECT_EN
//   defined   : a pop with an empty stack leaves ptr/count unchanged and
//               raises ret_underflow for that cycle.
//   undefined : a pop with an empty stack still walks ptr backwards (count
//               stays 0), reusing stale entries; ret_underflow is tied 0.
//
// Ports:
//   CLK               in   core clock
//   nRST              in   asynchronous active-low reset
//   link_valid        in   push request this cycle
//   link_pc38         in   return address to push
//   ret_valid         in   pop request this cycle
//   ret_pc38          out  predicted return target (current top entry)
//   ret_ras_index     out  current top pointer, for checkpointing
//   ret_ras_count     out  current valid count 0..RAS_ENTRIES, for checkpointing
//   ret_underflow     out  pop requested on an empty stack (macro only)
//   update_valid      in   mispredict restore request
//   update_ras_index  in   pointer to restore
//   update_ras_count  in   count to restore

module ras #(
  parameter int RAS_ENTRIES     = 16,
  parameter int LOG_RAS_ENTRIES = $clog2(RAS_ENTRIES)
) (
  input  logic                       CLK,
  input  logic                       nRST,

  input  logic                       link_valid,
  input  logic [37:0]                link_pc38,

  input  logic                       ret_valid,
  output logic [37:0]                ret_pc38,
  output logic [LOG_RAS_ENTRIES-1:0] ret_ras_index,
  output logic [LOG_RAS_ENTRIES:0]   ret_ras_count,
  output logic                       ret_underflow,

  input  logic                       update_valid,
  input  logic [LOG_RAS_ENTRIES-1:0] update_ras_index,
  input  logic [LOG_RAS_ENTRIES:0]   update_ras_count
);

  localparam logic [37:0]                INIT_PC38  = 38'h0;
  localparam logic [LOG_RAS_ENTRIES-1:0] PTR_ONE    = LOG_RAS_ENTRIES'(1);
  localparam logic [LOG_RAS_ENTRIES:0]   CNT_ZERO   = '0;
  localparam logic [LOG_RAS_ENTRIES:0]   CNT_ONE    = (LOG_RAS_ENTRIES+1)'(1);
  localparam logic [LOG_RAS_ENTRIES:0]   CNT_FULL   = (LOG_RAS_ENTRIES+1)'(RAS_ENTRIES);

  // One action per cycle, chosen by priority: restore beats everything,
  // then the four combinations of link/ret.
  typedef enum logic [2:0] {
    ACT_IDLE,
    ACT_UPDATE,
    ACT_PUSH,
    ACT_POP,
    ACT_REPLACE
  } action_t;

  action_t                    action;

  logic [37:0]                entry [RAS_ENTRIES];
  logic [LOG_RAS_ENTRIES-1:0] ptr;
  logic [LOG_RAS_ENTRIES:0]   count;

  logic [LOG_RAS_ENTRIES-1:0] ptr_next;
  logic [LOG_RAS_ENTRIES:0]   count_next;
  logic                       write_en;
  logic [LOG_RAS_ENTRIES-1:0] write_idx;
  logic                       pop_empty;

  // Read side: purely a function of current state, never of this cycle's
  // requests, so a RET_L still predicts the old top.
  assign ret_pc38      = entry[ptr];
  assign ret_ras_index = ptr;
  assign ret_ras_count = count;

  assign pop_empty = (action == ACT_POP) && (count == CNT_ZERO);

`ifdef LOROF_RAS_UNDERFLOW_PROTECT_EN
  assign ret_underflow = pop_empty;
`else
  assign ret_underflow = 1'b0;
`endif

  always_comb begin
    action = ACT_IDLE;
    if (update_valid) begin
      action = ACT_UPDATE;
    end else if (link_valid && !ret_valid) begin
      action = ACT_PUSH;
    end else if (!link_valid && ret_valid) begin
      action = ACT_POP;
    end else if (link_valid && ret_valid) begin
      action = ACT_REPLACE;
    end
  end

  // Next pointer/count and the single entry write port.
  always_comb begin
    ptr_next   = ptr;
    count_next = count;
    write_en   = 1'b0;
    write_idx  = ptr;
    unique case (action)
      ACT_UPDATE: begin
        ptr_next   = update_ras_index;
        count_next = update_ras_count;
      end
      ACT_PUSH: begin
        // When full the new target lands on the oldest slot; count saturates.
        ptr_next   = ptr + PTR_ONE;
        write_en   = 1'b1;
        write_idx  = ptr + PTR_ONE;
        count_next = (count == CNT_FULL) ? count : count + CNT_ONE;
      end
      ACT_POP: begin
        if (!pop_empty) begin
          ptr_next   = ptr - PTR_ONE;
          count_next = count - CNT_ONE;
        end else begin
`ifdef LOROF_RAS_UNDERFLOW_PROTECT_EN
          ptr_next   = ptr;
`else
          ptr_next   = ptr - PTR_ONE;
`endif
          count_next = CNT_ZERO;
        end
      end
      ACT_REPLACE: begin
        write_en   = 1'b1;
        write_idx  = ptr;
        count_next = (count == CNT_ZERO) ? CNT_ONE : count;
      end
      default: begin
        ptr_next   = ptr;
        count_next = count;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ptr   <= '0;
      count <= '0;
    end else begin
      ptr   <= ptr_next;
      count <= count_next;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < RAS_ENTRIES; i++) begin
        entry[i] <= INIT_PC38;
      end
    end else if (write_en) begin
      entry[write_idx] <= link_pc38;
    end
  end

endmodule

// File: tb/tb_ras.sv
// tb_ras -- self-checking bench for ras.
//
// Directed scenarios from the block's test plan plus a randomized run, all
// compared against a behavioural stack model held in this module. Expected
// underflow behaviour follows LOROF_RAS_UNDERFLOW_PROTECT_EN when defined.

module tb_ras;

  localparam int N = 16;

  logic        CLK;
  logic        nRST;
  logic        link_valid;
  logic [37:0] link_pc38;
  logic        ret_valid;
  logic [37:0] ret_pc38;
  logic [3:0]  ret_ras_index;
  logic [4:0]  ret_ras_count;
  logic        ret_underflow;
  logic        update_valid;
  logic [3:0]  update_ras_index;
  logic [4:0]  update_ras_count;

  int checks = 0;
  int errors = 0;

  // Behavioural model: an array of targets, a top index and a depth.
  logic [37:0] m_mem [N];
  int          m_ptr;
  int          m_cnt;

  ras dut (
    .CLK              (CLK),
    .nRST             (nRST),
    .link_valid       (link_valid),
    .link_pc38        (link_pc38),
    .ret_valid        (ret_valid),
    .ret_pc38         (ret_pc38),
    .ret_ras_index    (ret_ras_index),
    .ret_ras_count    (ret_ras_count),
    .ret_underflow    (ret_underflow),
    .update_valid     (update_valid),
    .update_ras_index (update_ras_index),
    .update_ras_count (update_ras_count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_mem[i] = 38'h0;
    m_ptr = 0;
    m_cnt = 0;
  endtask

  task automatic model_apply(input bit l, input logic [37:0] pc, input bit r,
                             input bit u, input int ui, input int uc);
    if (u) begin
      m_ptr = ui;
      m_cnt = uc;
    end else if (l && !r) begin
      m_ptr = (m_ptr + 1) % N;
      m_mem[m_ptr] = pc;
      if (m_cnt < N) m_cnt = m_cnt + 1;
    end else if (!l && r) begin
      if (m_cnt > 0) begin
        m_ptr = (m_ptr + N - 1) % N;
        m_cnt = m_cnt - 1;
      end else begin
`ifndef LOROF_RAS_UNDERFLOW_PROTECT_EN
        m_ptr = (m_ptr + N - 1) % N;
`endif
      end
    end else if (l && r) begin
      m_mem[m_ptr] = pc;
      if (m_cnt == 0) m_cnt = 1;
    end
  endtask

  function automatic bit model_underflow(input bit l, input bit r, input bit u);
`ifdef LOROF_RAS_UNDERFLOW_PROTECT_EN
    return r && !l && !u && (m_cnt == 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic set_inputs(input bit l, input logic [37:0] pc, input bit r,
                            input bit u, input int ui, input int uc);
    link_valid       = l;
    link_pc38        = pc;
    ret_valid        = r;
    update_valid     = u;
    update_ras_index = 4'(ui);
    update_ras_count = 5'(uc);
  endtask

  // Clock the applied inputs into DUT and model, then idle the inputs at #1.
  task automatic clock_step();
    @(posedge CLK);
    model_apply(link_valid, link_pc38, ret_valid, update_valid,
                int'(update_ras_index), int'(update_ras_count));
    #1;
    set_inputs(0, 38'h0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    set_inputs(0, 38'h0, 0, 0, 0, 0);
    nRST = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  task automatic push(input logic [37:0] pc);
    set_inputs(1, pc, 0, 0, 0, 0);
    clock_step();
  endtask

  task automatic pop();
    set_inputs(0, 38'h0, 1, 0, 0, 0);
    clock_step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (ret_pc38 !== 38'h0 || ret_ras_index !== 4'd0 || ret_ras_count !== 5'd0 ||
        ret_underflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: pc=%h idx=%0d cnt=%0d uf=%b, need 0/0/0/0",
               ret_pc38, ret_ras_index, ret_ras_count, ret_underflow);
    end
  endtask

  task automatic test_push_pop();
    do_reset();
    push(38'h100);
    checks++;
    if (ret_pc38 !== 38'h100 || ret_ras_index !== 4'd1 || ret_ras_count !== 5'd1) begin
      errors++;
      $display("[TB] FAIL push_first: pc=%h idx=%0d cnt=%0d, need 100/1/1",
               ret_pc38, ret_ras_index, ret_ras_count);
    end
    pop();
    checks++;
    if (ret_pc38 !== 38'h0 || ret_ras_index !== 4'd0 || ret_ras_count !== 5'd0) begin
      errors++;
      $display("[TB] FAIL pop_first: pc=%h idx=%0d cnt=%0d, need 0/0/0",
               ret_pc38, ret_ras_index, ret_ras_count);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 17; i++) push(38'(i));
    checks++;
    if (ret_pc38 !== 38'h11 || ret_ras_index !== 4'd1 || ret_ras_count !== 5'd16) begin
      errors++;
      $display("[TB] FAIL overflow_full: pc=%h idx=%0d cnt=%0d, need 11/1/16",
               ret_pc38, ret_ras_index, ret_ras_count);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (ret_pc38 !== 38'(17 - i)) begin
        errors++;
        $display("[TB] FAIL overflow_pop%0d: pc=%h, need %h", i, ret_pc38, 38'(17 - i));
      end
      pop();
    end
    checks++;
    if (ret_ras_count !== 5'd0) begin
      errors++;
      $display("[TB] FAIL overflow_drain: cnt=%0d, need 0", ret_ras_count);
    end
  endtask

  task automatic test_ret_l();
    do_reset();
    push(38'hA);
    push(38'hB);
    set_inputs(1, 38'hC, 1, 0, 0, 0);
    #2;
    checks++;
    if (ret_pc38 !== 38'hB) begin
      errors++;
      $display("[TB] FAIL retl_same_cycle: pc=%h, need b", ret_pc38);
    end
    clock_step();
    checks++;
    if (ret_pc38 !== 38'hC || ret_ras_index !== 4'd2 || ret_ras_count !== 5'd2) begin
      errors++;
      $display("[TB] FAIL retl_after: pc=%h idx=%0d cnt=%0d, need c/2/2",
               ret_pc38, ret_ras_index, ret_ras_count);
    end
  endtask

  task automatic test_restore();
    do_reset();
    push(38'h1);
    push(38'h2);
    push(38'h3);
    pop();
    pop();
    set_inputs(1, 38'h9, 0, 1, 3, 3);
    clock_step();
    checks++;
    if (ret_pc38 !== 38'h3 || ret_ras_index !== 4'd3 || ret_ras_count !== 5'd3) begin
      errors++;
      $display("[TB] FAIL restore: pc=%h idx=%0d cnt=%0d, need 3/3/3",
               ret_pc38, ret_ras_index, ret_ras_count);
    end
    pop();
    checks++;
    if (ret_pc38 !== 38'h2) begin
      errors++;
      $display("[TB] FAIL restore_no_write: pc=%h, need 2", ret_pc38);
    end
  endtask

  task automatic test_underflow();
    bit          exp_uf;
    logic [3:0]  exp_idx;
    do_reset();
`ifdef LOROF_RAS_UNDERFLOW_PROTECT_EN
    exp_uf  = 1'b1;
    exp_idx = 4'd0;
`else
    exp_uf  = 1'b0;
    exp_idx = 4'd15;
`endif
    set_inputs(0, 38'h0, 1, 0, 0, 0);
    #2;
    checks++;
    if (ret_underflow !== exp_uf) begin
      errors++;
      $display("[TB] FAIL underflow_flag: uf=%b, need %b", ret_underflow, exp_uf);
    end
    clock_step();
    checks++;
    if (ret_ras_index !== exp_idx || ret_ras_count !== 5'd0 || ret_underflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL underflow_state: idx=%0d cnt=%0d uf=%b, need %0d/0/0",
               ret_ras_index, ret_ras_count, ret_underflow, exp_idx);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 5; i++) push(38'h50 + 38'(i));
    checks++;
    if (ret_ras_count !== 5'd5 || ret_pc38 !== 38'h54) begin
      errors++;
      $display("[TB] FAIL async_pre: cnt=%0d pc=%h, need 5/54", ret_ras_count, ret_pc38);
    end
    set_inputs(1, 38'h77, 0, 0, 0, 0);
    #3;
    nRST = 1'b0;
    model_reset();
    #1;
    checks++;
    if (ret_pc38 !== 38'h0 || ret_ras_index !== 4'd0 || ret_ras_count !== 5'd0) begin
      errors++;
      $display("[TB] FAIL async_reset: pc=%h idx=%0d cnt=%0d, need 0/0/0",
               ret_pc38, ret_ras_index, ret_ras_count);
    end
    set_inputs(0, 38'h0, 0, 0, 0, 0);
    #1;
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    checks++;
    if (ret_ras_count !== 5'd0 || ret_ras_index !== 4'd0) begin
      errors++;
      $display("[TB] FAIL async_after: idx=%0d cnt=%0d, need 0/0",
               ret_ras_index, ret_ras_count);
    end
  endtask

  task automatic test_random();
    int          sel;
    bit          l, r, u;
    logic [37:0] pc;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      sel = int'($urandom_range(0, 99));
      u   = (sel < 6);
      l   = ($urandom_range(0, 99) < 50);
      r   = ($urandom_range(0, 99) < 45);
      pc  = {6'($urandom), 32'($urandom)};
      set_inputs(l, pc, r, u, int'($urandom_range(0, N - 1)), int'($urandom_range(0, N)));
      #2;
      checks++;
      if (ret_pc38 !== m_mem[m_ptr] || ret_ras_index !== 4'(m_ptr) ||
          ret_ras_count !== 5'(m_cnt) || ret_underflow !== model_underflow(l, r, u)) begin
        errors++;
        $display("[TB] FAIL random_%0d: pc=%h idx=%0d cnt=%0d uf=%b, need %h/%0d/%0d/%b",
                 n, ret_pc38, ret_ras_index, ret_ras_count, ret_underflow,
                 m_mem[m_ptr], m_ptr, m_cnt, model_underflow(l, r, u));
      end
      clock_step();
    end
  endtask

  initial begin
    nRST = 1'b0;
    set_inputs(0, 38'h0, 0, 0, 0, 0);
    model_reset();
    test_reset();
    test_push_pop();
    test_overflow();
    test_ret_l();
    test_restore();
    test_underflow();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
